// File: rtl/wb_commit.sv
// Commit stage: owns EFLAGS, drives the register-file write port and runs stores over a req/ack handshake.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_commit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v,
  input  logic        mwe,
  input  logic        rfwe,
  input  logic [2:0]  drid,
  input  logic [31:0] aluval,
  input  logic [31:0] maddr,
  input  logic [31:0] flags,
  input  logic [31:0] flagwe,
  input  logic        mem_ack,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        rf_we,
  output logic [2:0]  rf_id,
  output logic [31:0] rf_data,
  output logic [31:0] eflags
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STORE = 1'b1
  } state_t;

  localparam logic [31:0] FLAG_MASK  = 32'h0000_08D5;
  localparam logic [31:0] EFLAGS_RST = 32'h0000_0002;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_mem_req;
  logic        w_mem_req_next;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_next;
  logic [31:0] r_mem_data;
  logic [31:0] w_mem_data_next;
  logic [31:0] r_eflags;
  logic [31:0] w_eflags_next;
  logic        w_ack;
  logic        w_commit;
  logic [31:0] w_fmask;

  assign w_ack    = (r_state == S_STORE) & mem_ack;
  assign w_commit = v & (~mwe | w_ack);
  assign w_fmask  = flagwe & FLAG_MASK;

  assign stall    = v & mwe & ~w_ack;
  assign rf_we    = w_commit & rfwe;
  assign rf_id    = drid;
  assign rf_data  = aluval;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign eflags   = r_eflags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_mem_data <= 32'h0;
      r_eflags   <= EFLAGS_RST;
    end else begin
      r_state    <= w_state_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_data <= w_mem_data_next;
      r_eflags   <= w_eflags_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mem_req_next  = r_mem_req;
    w_mem_addr_next = r_mem_addr;
    w_mem_data_next = r_mem_data;
    case (r_state)
      S_IDLE: begin
        if (v & mwe) begin
          w_state_next    = S_STORE;
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = maddr;
          w_mem_data_next = aluval;
        end
      end
      S_STORE: begin
        if (mem_ack) begin
          w_state_next   = S_IDLE;
          w_mem_req_next = 1'b0;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  // Bit 1 is or-ed back in so it reads 1 even if the register were ever disturbed.
  always_comb begin
    w_eflags_next = r_eflags;
    if (w_commit) begin
      w_eflags_next = (r_eflags & ~w_fmask) | (flags & w_fmask) | EFLAGS_RST;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 32'h0;
    end else if (w_commit) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed test-plan checks plus randomized traffic against a transaction-level model.
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v, mwe, rfwe, mem_ack;
  logic [2:0]  drid;
  logic [31:0] aluval, maddr, flags, flagwe;
  logic        stall, mem_req, rf_we;
  logic [31:0] mem_addr, mem_data, rf_data, eflags;
  logic [2:0]  rf_id;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_commit dut (
    .clk(clk), .rst_n(rst_n), .v(v), .mwe(mwe), .rfwe(rfwe), .drid(drid),
    .aluval(aluval), .maddr(maddr), .flags(flags), .flagwe(flagwe), .mem_ack(mem_ack),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_id(rf_id), .rf_data(rf_data), .eflags(eflags)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding store (address/data) and the architectural flag image.
  bit          chk_on = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_eflags = 32'h2;
  logic [31:0] m_cnt = 32'h0;
  bit          e_commit, e_stall, acked;
  logic [31:0] msk;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0; m_addr = 32'h0; m_data = 32'h0; m_eflags = 32'h2; m_cnt = 32'h0;
    end
    acked    = m_pend && mem_ack;
    e_commit = v && (!mwe || acked);
    e_stall  = v && mwe && !acked;
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("rf_we", 32'(rf_we), 32'(e_commit && rfwe));
      chk("rf_id", 32'(rf_id), 32'(drid));
      chk("rf_data", rf_data, aluval);
      chk("mem_req", 32'(mem_req), 32'(m_pend));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("eflags", eflags, m_eflags);
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, m_cnt);
`endif
    end
    if (rst_n) begin
      if (e_commit) begin
        msk      = flagwe & 32'h0000_08D5;
        m_eflags = (m_eflags & ~msk) | (flags & msk);
        m_cnt    = m_cnt + 32'd1;
      end
      if (acked) begin
        m_pend = 1'b0;
      end else if (!m_pend && v && mwe) begin
        m_pend = 1'b1; m_addr = maddr; m_data = aluval;
      end
    end
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int       stalls;
  int       commits;
  logic [2:0] reqs;
  bit       held;

  initial begin
    rst_n = 1'b1; v = 0; mwe = 0; rfwe = 0; drid = 0; aluval = 0; maddr = 0;
    flags = 0; flagwe = 0; mem_ack = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    mid();
    chk("reset mem_req", 32'(mem_req), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_data", mem_data, 32'h0);
    chk("reset eflags", eflags, 32'h2);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset rf_we", 32'(rf_we), 32'h0);
    chk_on = 1'b1;

    // Register write commits in its own cycle.
    edge_(); rst_n = 1; v = 1; rfwe = 1; drid = 3; aluval = 32'h1234_5678;
    mid();
    chk("rfw rf_we", 32'(rf_we), 32'h1);
    chk("rfw rf_id", 32'(rf_id), 32'h3);
    chk("rfw rf_data", rf_data, 32'h1234_5678);
    chk("rfw stall", 32'(stall), 32'h0);

    // Flag updates.
    edge_(); rfwe = 0; flags = 32'hFFFF_FFFF; flagwe = 32'hFFFF_FFFF;
    mid();
    edge_(); flags = 0; flagwe = 32'h1;
    mid();
    chk("flags all", eflags, 32'h0000_08D7);
    edge_(); v = 0; flagwe = 0;
    mid();
    chk("flags cf clr", eflags, 32'h0000_08D6);

    // Store with three ack-less STORE cycles.
    edge_(); v = 1; mwe = 1; maddr = 32'h100; aluval = 32'hCAFE_F00D; mem_ack = 0;
    mid();
    stalls = int'(stall);
    chk("st arrive req", 32'(mem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_();
      mid();
      stalls += int'(stall);
      chk("st req", 32'(mem_req), 32'h1);
      chk("st addr", mem_addr, 32'h100);
      chk("st data", mem_data, 32'hCAFE_F00D);
    end
    edge_(); mem_ack = 1;
    mid();
    stalls += int'(stall);
    edge_(); v = 0; mwe = 0; mem_ack = 0;
    mid();
    chk("st req drop", 32'(mem_req), 32'h0);
    chk("st stall cycles", 32'(stalls), 32'd4);

    // Back-to-back stores, ack held high (ignored on arrival).
    commits = 0;
    edge_(); v = 1; mwe = 1; maddr = 32'h200; aluval = 32'hAAAA_0001; mem_ack = 1;
    mid(); commits += int'(v && !stall);
    edge_();
    mid(); commits += int'(v && !stall); reqs[2] = mem_req;
    chk("b2b addr1", mem_addr, 32'h200);
    edge_(); maddr = 32'h300; aluval = 32'hBBBB_0002;
    mid(); commits += int'(v && !stall); reqs[1] = mem_req;
    edge_();
    mid(); commits += int'(v && !stall); reqs[0] = mem_req;
    chk("b2b addr2", mem_addr, 32'h300);
    edge_(); v = 0; mwe = 0; mem_ack = 0;
    mid();
    chk("b2b req wave", 32'(reqs), 32'h5);
    chk("b2b commits", 32'(commits), 32'd2);

    // Reset while a store is outstanding.
    edge_(); v = 1; mwe = 1; rfwe = 1; maddr = 32'h400; aluval = 32'h0BAD_BEEF;
    mid();
    edge_();
    mid();
    chk("rst pre req", 32'(mem_req), 32'h1);
    edge_(); rst_n = 0;
    mid();
    chk("rst req", 32'(mem_req), 32'h0);
    chk("rst eflags", eflags, 32'h2);
    chk("rst rf_we", 32'(rf_we), 32'h0);
    edge_(); rst_n = 1; rfwe = 0; mem_ack = 1;
    mid();
    chk("rst idle stall", 32'(stall), 32'h1);
    edge_();
    mid();
    chk("rst ack stall", 32'(stall), 32'h0);
    edge_(); mwe = 0; mem_ack = 0;
    mid();
    edge_(); v = 0;
    mid();
`ifdef WB_RETIRE_CNT_EN
    chk("retire two", retire_cnt, 32'd2);
`endif

    // Randomized traffic; inputs are held while the DUT stalls.
    held = 1'b0;
    repeat (3000) begin
      edge_();
      if (!rst_n) begin
        rst_n = 1'b1;
        held  = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
      end
      if (!held) begin
        v      = ($urandom_range(3) != 0);
        mwe    = v && ($urandom_range(2) == 0);
        rfwe   = v && (mwe ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0));
        drid   = 3'($urandom);
        aluval = $urandom;
        maddr  = $urandom;
        flags  = $urandom;
        flagwe = ($urandom_range(1) == 0) ? $urandom : (32'h1 << $urandom_range(11));
      end
      mem_ack = ($urandom_range(2) == 0);
      mid();
      held = rst_n && stall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
